serial_word_rx: RTL

Downstream consumer of the 32-bit shift register's serial output (s_out). It frames and deserializes a WIDTH-bit word from the serial stream, honouring the same dir convention as the register. It presents each completed word through a one-entry valid/ready output buffer, and flags overruns when the consumer stalls.

---
 rtl/serial_word_rx.sv | 104 ++++++++++
 1 files changed

// File: rtl/serial_word_rx.sv
// serial_word_rx: frames and deserializes a WIDTH-bit word from a serial
// stream and presents it through a one-entry valid/ready buffer. A word that
// completes while the buffer is still full is dropped, and a sticky overrun
// flag records the drop.
module serial_word_rx #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic             s_in,
  input  logic             ready,
  output logic [WIDTH-1:0] word_out,
  output logic             valid,
  output logic             busy,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  typedef enum logic {IDLE, RECV} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             dir_l;

  logic             sel_dir;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] shift_in;
  logic             complete;

  // Next shift-register value. At start the frame begins from an empty
  // register and uses the live dir, since dir_l is only latched on that edge.
  always_comb begin
    sel_dir  = (state == IDLE) ? dir : dir_l;
    base     = (state == IDLE) ? '0 : shreg;
    shift_in = sel_dir ? {s_in, base[WIDTH-1:1]} : {base[WIDTH-2:0], s_in};
    complete = (state == RECV) && enb && !abort && (bit_cnt == LAST);
  end

  assign busy = (state == RECV);

  // Framing FSM: start opens a frame, abort drops it, WIDTH bits close it.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      dir_l   <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RECV;
            dir_l   <= dir;
            shreg   <= enb ? shift_in : '0;
            bit_cnt <= enb ? CW'(1) : '0;
          end
        end
        RECV: begin
          if (enb) begin
            shreg <= shift_in;
            if (complete) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer: load on completion if empty or draining this cycle,
  // otherwise drop the word and flag overrun.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      word_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else if (complete) begin
      if (!valid || ready) begin
        word_out <= shift_in;
        valid    <= 1'b1;
      end else begin
        overrun  <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule
